// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional write-to-read forwarding is selected by REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

   localparam int RF_DATA_W = 64;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the issue/datapath side (master) and the register file (slave).
// Reads have no handshake: an address is sampled every cycle and answered one edge later.
interface regfile_mp_if
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD
) ();

   logic                     ready;
   rf_state_e                state;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_pending;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;

   modport master (
      input  ready, state, rd_data, rd_pending,
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
   );

   modport slave (
      output ready, state, rd_data, rd_pending,
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr
   );

endinterface

// File: rtl/regfile_mp_rdport.sv
// One registered read port: latches array data and scoreboard bit for its address.
// With REGFILE_MP_BYPASS_EN defined, a same-cycle write to the same address is forwarded.
module regfile_mp_rdport #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] arr_data,
   input  logic              sb_bit,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_pending
);

   logic [DATA_W-1:0] nxt_data;
   logic              nxt_pending;

`ifdef REGFILE_MP_BYPASS_EN
   // A forwarded write clears the pending bit unless a new producer reserves it in the same cycle.
   always_comb begin
      nxt_data    = arr_data;
      nxt_pending = sb_bit;
      if (wr_en && (wr_addr == addr)) begin
         nxt_data    = wr_data;
         nxt_pending = rsv_en && (rsv_addr == addr);
      end
   end
`else
   logic unused_fwd;
   assign nxt_data    = arr_data;
   assign nxt_pending = sb_bit;
   assign unused_fwd  = ^{wr_en, wr_addr, wr_data, rsv_en, rsv_addr};
`endif

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         rd_data    <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_data    <= nxt_data;
         rd_pending <= nxt_pending;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with RAW scoreboard and a reset-time clear sweep.
// Define REGFILE_MP_BYPASS_EN to enable write-to-read forwarding in the read ports.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   rf_state_e                state;
   logic [ADDR_W-1:0]        clr_idx;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic [DEPTH-1:0]         sb;
   logic                     run;
   logic [NUM_RD*DATA_W-1:0] rd_data_all;
   logic [NUM_RD-1:0]        rd_pending_all;

   assign run            = (state == RF_RUN);
   assign bus.ready      = run;
   assign bus.state      = state;
   assign bus.rd_data    = rd_data_all;
   assign bus.rd_pending = rd_pending_all;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RF_CLEAR;
         clr_idx <= '0;
      end else if (state == RF_CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (&clr_idx) state <= RF_RUN;
      end
   end

   // No reset on the array itself so it can map onto a RAM; the sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == RF_CLEAR) mem[clr_idx] <= '0;
         else if (bus.wr_en)    mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // The reserve is written last so it wins over a same-address write.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb <= '0;
      end else if (run) begin
         if (bus.wr_en)  sb[bus.wr_addr]  <= 1'b0;
         if (bus.rsv_en) sb[bus.rsv_addr] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

      regfile_mp_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rdport (
         .clk        (clk),
         .rst        (rst),
         .run        (run),
         .addr       (addr),
         .arr_data   (mem[addr]),
         .sb_bit     (sb[addr]),
         .wr_en      (bus.wr_en),
         .wr_addr    (bus.wr_addr),
         .wr_data    (bus.wr_data),
         .rsv_en     (bus.rsv_en),
         .rsv_addr   (bus.rsv_addr),
         .rd_data    (rd_data_all[i*DATA_W +: DATA_W]),
         .rd_pending (rd_pending_all[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed and random traffic against an array/bit-vector model.
// Expectations follow REGFILE_MP_BYPASS_EN when it is defined for the build.
module tb_regfile_mp;
   import regfile_mp_pkg::*;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int W      = NUM_RD*DATA_W + NUM_RD;

   logic clk;
   logic rst;

   regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

   regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model
   logic [DATA_W-1:0] mem_m [DEPTH];
   logic [DEPTH-1:0]  sb_m;

   logic [W-1:0] exp_q[$];
   int           errors = 0;
   int           checks = 0;
   logic         rd_issued = 1'b0;
   logic         rd_valid  = 1'b0;

   task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      sb_m = '0;
   endtask

   // drivers
   task automatic idle_inputs();
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.rsv_en   = 1'b0;
      bus.rsv_addr = '0;
      bus.rd_addr  = '0;
      rd_issued    = 1'b0;
   endtask

   // Reset then let the sweep run; optionally poke wr/rsv or re-assert rst at a given clear cycle.
   task automatic sweep(input int inject_at, input int rerst_at);
      int k;
      bit done;
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_clear();
      check("reset_ready", {63'd0, bus.ready}, 64'd0);
      check("reset_rd_data", bus.rd_data[63:0] | bus.rd_data[127:64], 64'd0);
      check("reset_rd_pending", {62'd0, bus.rd_pending}, 64'd0);
      k = 0;
      done = 1'b0;
      while (!done) begin
         if (k == inject_at) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 64'hFF;
            bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
         end
         if (k == rerst_at) rst = 1'b1;
         @(posedge clk); #1;
         bus.wr_en = 1'b0;
         bus.rsv_en = 1'b0;
         if (rst) begin
            rst = 1'b0;
            rerst_at = -1;
            k = 0;
            check("rerst_ready", {63'd0, bus.ready}, 64'd0);
         end else begin
            k++;
            check($sformatf("sweep_ready_edge%0d", k), {63'd0, bus.ready}, {63'd0, (k == DEPTH)});
            if (k == DEPTH) done = 1'b1;
         end
      end
   endtask

   // One RUN cycle: expected read result comes from the model before the edge.
   task automatic cycle(input bit we, input int wa, input logic [DATA_W-1:0] wd,
                        input bit re, input int ra, input int a0, input int a1);
      logic [W-1:0]      e;
      int                addr [NUM_RD];
      logic [DATA_W-1:0] d;
      logic              pd;
      addr[0] = a0;
      addr[1] = a1;
      bus.wr_en    = we;
      bus.wr_addr  = ADDR_W'(wa);
      bus.wr_data  = wd;
      bus.rsv_en   = re;
      bus.rsv_addr = ADDR_W'(ra);
      bus.rd_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
      e = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         d  = mem_m[addr[p]];
         pd = sb_m[addr[p]];
`ifdef REGFILE_MP_BYPASS_EN
         if (we && wa == addr[p]) begin
            d  = wd;
            pd = re && (ra == addr[p]);
         end
`endif
         e[p*DATA_W +: DATA_W] = d;
         e[NUM_RD*DATA_W + p]  = pd;
      end
      exp_q.push_back(e);
      rd_issued = 1'b1;
      @(posedge clk);
      if (we) begin
         mem_m[wa] = wd;
         sb_m[wa]  = 1'b0;
      end
      if (re) sb_m[ra] = 1'b1;
      #1;
   endtask

   task automatic drain();
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic read_all();
      for (int a = 0; a < DEPTH; a++) cycle(1'b0, 0, '0, 1'b0, 0, a, DEPTH - 1 - a);
      drain();
   endtask

   // scoreboard monitor
   always @(posedge clk) rd_valid <= rd_issued;

   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] e;
      if (rd_valid) begin
         got = {bus.rd_pending, bus.rd_data};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got=%0h expected=<none>", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL rd_port: got=%0h expected=%0h", got, e);
            end
         end
      end
   end

   // stimulus
   initial begin
      int wa, ra, a0;
      idle_inputs();
      rst = 1'b0;
      @(posedge clk); #1;

      sweep(-1, -1);
      read_all();

      cycle(1'b1, 7, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0, 0);
      cycle(1'b0, 0, '0, 1'b0, 0, 7, 7);
      cycle(1'b1, 3, 64'h55, 1'b0, 0, 3, 7);
      cycle(1'b0, 0, '0, 1'b0, 0, 3, 3);
      cycle(1'b0, 0, '0, 1'b1, 9, 0, 0);
      cycle(1'b0, 0, '0, 1'b0, 0, 9, 9);
      cycle(1'b1, 9, 64'h1234, 1'b0, 0, 9, 1);
      cycle(1'b0, 0, '0, 1'b0, 0, 9, 9);
      cycle(1'b1, 9, 64'h5678, 1'b1, 9, 9, 2);
      cycle(1'b0, 0, '0, 1'b0, 0, 9, 9);
      cycle(1'b1, 0, 64'hA5A5, 1'b0, 0, 0, 0);
      cycle(1'b0, 0, '0, 1'b0, 0, 0, 0);
      drain();

      for (int n = 0; n < 300; n++) begin
         wa = $urandom_range(0, DEPTH - 1);
         ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         cycle($urandom_range(0, 1) == 1, wa, {$urandom, $urandom},
               $urandom_range(0, 2) == 0, ra, a0, $urandom_range(0, DEPTH - 1));
      end
      drain();

      sweep(10, -1);
      read_all();

      for (int n = 0; n < 20; n++)
         cycle(1'b1, $urandom_range(0, DEPTH - 1), {$urandom, $urandom}, 1'b1,
               $urandom_range(0, DEPTH - 1), 0, 1);
      drain();

      sweep(-1, 20);
      read_all();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL exp_q_drained: got=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
